// File: rtl/mips_multi_pkg.sv
// Shared definitions for the bus-attached multicycle MIPS core: opcodes, ALU ops, FSM states.
// The optional bne decode is controlled by MIPS_MULTI_BNE_EN in mips_multi_bus.
package mips_multi_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_MEMADR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_ADDI_EX, S_ADDI_WB, S_TRAP
  } state_e;

  // add/sub wrap silently; slt compares as two's complement
  function automatic logic [31:0] alu_fn(input alu_op_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, (sa < sb)};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_multi_alu.sv
// 32-bit ALU with zero flag used for branch compare.
module mips_multi_alu
  import mips_multi_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        zero
);

  assign y    = alu_fn(op, a, b);
  assign zero = (y == 32'b0);

endmodule

// File: rtl/mips_multi_bus.sv
// Multicycle MIPS-subset core with req/ack memory bus, addi, illegal-opcode trap and retire pulse.
// Define MIPS_MULTI_BNE_EN to decode bne (op 0x05); otherwise it traps as illegal.
module mips_multi_bus
  import mips_multi_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              trap
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       alu_out_q, alu_out_d;
  logic [31:0]       mdr_q, mdr_d;
  logic [31:0]       rf_q [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, pc_ext, rs_val, rt_val;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  alu_op_e     alu_op, r_op;
  logic        r_ok, take;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_zero;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext = 32'(pc_q);
  assign rs_val = (rs == 5'd0) ? 32'b0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'b0 : rf_q[rt];
  assign pc     = pc_q;

  always_comb begin
    r_ok = 1'b1;
    r_op = ALU_ADD;
    case (funct)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      default: r_ok = 1'b0;
    endcase
  end

  // Shared ALU: PC+1+simm in DECODE, A op B for R-type/branch, A+simm otherwise
  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = a_q;
    alu_b  = simm;
    case (state_q)
      S_DECODE: alu_a = pc_ext;
      S_EXEC_R: begin
        alu_b  = b_q;
        alu_op = r_op;
      end
      S_BRANCH: begin
        alu_b  = b_q;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

  mips_multi_alu u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

`ifdef MIPS_MULTI_BNE_EN
  assign take = (opcode == OP_BNE) ? !alu_zero : alu_zero;
`else
  assign take = alu_zero;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    rf_we     = 1'b0;
    rf_waddr  = rt;
    rf_wdata  = alu_out_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 32'b0;
    retire    = 1'b0;
    trap      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d       = rs_val;
        b_d       = rt_val;
        alu_out_d = alu_y;
        case (opcode)
          OP_RTYPE:     state_d = r_ok ? S_EXEC_R : S_TRAP;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MIPS_MULTI_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_out_d = alu_y;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rd;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        alu_out_d = alu_y;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = alu_out_q[ADDR_W-1:0];
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        rf_we    = 1'b1;
        rf_wdata = mdr_q;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = alu_out_q[ADDR_W-1:0];
        mem_wdata = b_q;
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        if (take) pc_d = alu_out_q[ADDR_W-1:0];
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = ir_q[ADDR_W-1:0];
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_out_d = alu_y;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'b0;
      a_q       <= 32'b0;
      b_q       <= 32'b0;
      alu_out_q <= 32'b0;
      mdr_q     <= 32'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end

  // Register file is never cleared; r0 is forced to zero on read
  always_ff @(posedge clk) begin
    if (rf_we && !rst && (rf_waddr != 5'd0)) rf_q[rf_waddr] <= rf_wdata;
  end

endmodule

// File: tb/tb_mips_multi_bus.sv
// Directed bench for mips_multi_bus: bus memory model with random wait states, retire timing, trap.
module tb_mips_multi_bus;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req, mem_we, retire, trap;
  logic [AW-1:0] mem_addr, pc;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'b0;
  logic          mem_ack = 1'b0;

  always #5 clk = ~clk;

  mips_multi_bus #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc(pc),
    .retire(retire), .trap(trap)
  );

  logic [31:0]   mem [256];
  int            checks = 0, errors = 0;
  int            cyc = 0, wait_max = 0, wcnt = 0, nwrites = 0, stab_err = 0, freq = -1;
  bit            done_flag = 0, in_x = 0, swe = 0;
  logic [AW-1:0] sa = '0;
  logic [31:0]   swd = 32'b0;
  int            rt_q[$];
  int            reqs;
  logic [31:0]   exp_bne_trap;

  // Edge-side bookkeeping: completed writes, retire times, bus stability
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        nwrites++;
      end
      done_flag = 1;
    end
    if (retire) rt_q.push_back(cyc);
    if (mem_req && freq < 0) freq = cyc;
    if (mem_req) begin
      if (in_x && (mem_addr !== sa || mem_we !== swe || (mem_we && mem_wdata !== swd)))
        stab_err++;
      sa   = mem_addr;
      swe  = mem_we;
      swd  = mem_wdata;
      in_x = !mem_ack;
    end else begin
      in_x = 0;
    end
    cyc++;
  end

  // Bus responder with 0..wait_max wait cycles per transfer
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!mem_req || done_flag) begin
      wcnt      = (wait_max > 0) ? int'($urandom_range(wait_max, 0)) : 0;
      done_flag = 0;
    end
    if (mem_req) begin
      if (wcnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
      end else begin
        wcnt--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    for (int i = 0; i < 256; i++) mem[i] = 32'b0;
    nwrites  = 0;
    stab_err = 0;
    freq     = -1;
    rt_q.delete();
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && nwrites < n; i++) step();
    check(tag, 32'(nwrites), 32'(n));
  endtask

  task automatic wait_retires(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rt_q.size() < n; i++) step();
    check(tag, 32'(rt_q.size()), 32'(n));
  endtask

  task automatic load_prog2();
    mem[0] = 32'h20010005;  // addi r1,r0,5
    mem[1] = 32'h20020007;  // addi r2,r0,7
    mem[2] = 32'h00221820;  // add  r3,r1,r2
    mem[3] = 32'hAC030010;  // sw   r3,0x10(r0)
    mem[4] = 32'h08000004;  // j 4
  endtask

  initial begin
    // Reset state and first fetch
    do_reset();
    load_prog2();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    rst = 1'b0;
    #1;
    check("idle_req", 32'(mem_req), 32'd0);
    step();
    check("fetch_req", 32'(mem_req), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'd0);
    check("fetch_we", 32'(mem_we), 32'd0);

    // Zero-wait program: sw writes 12 to 0x10, 4 cycles per instruction
    wait_writes("t2_timeout", 1, 200);
    check("t2_mem10", mem[16], 32'd12);
    check("t2_first", 32'(rt_q[0] - freq), 32'd3);
    check("t2_int1", 32'(rt_q[1] - rt_q[0]), 32'd4);
    check("t2_int2", 32'(rt_q[2] - rt_q[1]), 32'd4);
    check("t2_int3", 32'(rt_q[3] - rt_q[2]), 32'd4);

    // Same program with random wait states
    do_reset();
    load_prog2();
    wait_max = 5;
    rst = 1'b0;
    wait_writes("t3_timeout", 1, 400);
    check("t3_mem10", mem[16], 32'd12);
    check("t3_stable", 32'(stab_err), 32'd0);
    check("t3_retires", 32'(rt_q.size()), 32'd4);
    wait_max = 0;

    // lw/sw round trip and r0 write ignored
    do_reset();
    mem[0]  = 32'h8C040010;  // lw   r4,0x10(r0)
    mem[1]  = 32'hAC040011;  // sw   r4,0x11(r0)
    mem[2]  = 32'h20000009;  // addi r0,r0,9
    mem[3]  = 32'hAC000012;  // sw   r0,0x12(r0)
    mem[4]  = 32'h08000004;  // j 4
    mem[16] = 32'hDEADBEEF;
    mem[18] = 32'h55555555;
    rst = 1'b0;
    wait_writes("t4_timeout", 2, 200);
    check("t4_mem11", mem[17], 32'hDEADBEEF);
    check("t4_mem12", mem[18], 32'd0);
    check("t4_lw_cyc", 32'(rt_q[0] - freq), 32'd4);

    // beq r0,r0,-1 at PC 3 loops to itself
    do_reset();
    mem[0] = 32'h20010001;
    mem[1] = 32'h20020002;
    mem[2] = 32'h20030003;
    mem[3] = 32'h1000FFFF;  // beq r0,r0,-1
    rst = 1'b0;
    wait_retires("t5_beq_to", 4, 100);
    check("t5_beq_req", 32'(mem_req), 32'd1);
    check("t5_beq_addr", 32'(mem_addr), 32'd3);
    check("t5_beq_pc", 32'(pc), 32'd3);
    check("t5_beq_cyc", 32'(rt_q[3] - rt_q[2]), 32'd3);

    // j 0xFF, then PC+1 wraps to 0
    do_reset();
    mem[0]   = 32'h080000FF;  // j 0xFF
    mem[255] = 32'h20070077;  // addi r7,r0,0x77
    rst = 1'b0;
    wait_retires("t5_j_to", 1, 50);
    check("t5_j_pc", 32'(pc), 32'hFF);
    check("t5_j_addr", 32'(mem_addr), 32'hFF);
    check("t5_j_cyc", 32'(rt_q[0] - freq), 32'd2);
    wait_retires("t5_wrap_to", 2, 50);
    check("t5_wrap_pc", 32'(pc), 32'd0);
    check("t5_wrap_addr", 32'(mem_addr), 32'd0);

    // Illegal opcode 0x3F traps after DECODE
    do_reset();
    mem[0] = 32'hFC000000;
    rst = 1'b0;
    step();
    step();
    check("t6_decode_trap", 32'(trap), 32'd0);
    step();
    check("t6_trap", 32'(trap), 32'd1);
    check("t6_trap_req", 32'(mem_req), 32'd0);
    check("t6_trap_pc", 32'(pc), 32'd1);
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      reqs += int'(mem_req);
    end
    check("t6_trap_quiet", 32'(reqs), 32'd0);
    check("t6_sticky", 32'(trap), 32'd1);
    rst = 1'b1;
    step();
    check("t6_rst_clear", 32'(trap), 32'd0);
    check("t6_rst_pc", 32'(pc), 32'd0);

    // Op 0x05 traps only without bne support
    do_reset();
    mem[0] = 32'h14000005;  // bne r0,r0,5 (not taken when decoded)
    mem[1] = 32'h08000001;  // j 1
`ifdef MIPS_MULTI_BNE_EN
    exp_bne_trap = 32'd0;
`else
    exp_bne_trap = 32'd1;
`endif
    rst = 1'b0;
    step();
    step();
    step();
    check("t6_bne_trap", 32'(trap), exp_bne_trap);
    check("t6_bne_retire", 32'(retire), 32'(exp_bne_trap == 32'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
